// File: rtl/ciclo_bus_rtc.sv
// ciclo_bus_rtc: multiplexed address/data bus-cycle generator for the external RTC.
// Ports: clk, reset (sync, active low); actesc/actlec requests with dir/dato
// operands; ad_in read-back from the AD pins; cs_n/rd_n/wr_n/a_d strobes,
// ad_out/ad_oe pin drive; esclisto/memorialisto done flags; datomem read byte.
module ciclo_bus_rtc #(
  parameter int T_SU  = 1,
  parameter int T_PW  = 3,
  parameter int T_HD  = 1,
  parameter int T_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       actesc,
  input  logic       actlec,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic [7:0] ad_in,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       esclisto,
  output logic       memorialisto,
  output logic [7:0] datomem
);
  // Phase states are numbered consecutively so a timed state advances by +1.
  typedef enum logic [3:0] {IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [7:0] dir_q, dato_q;
  logic wr_op, tc, req, addr_ph, data_ph;
  function automatic logic [3:0] dur(state_t s);
    return (s == A_SU || s == D_SU) ? 4'(T_SU - 1) :
           (s == A_PW || s == D_PW) ? 4'(T_PW - 1) :
           (s == A_HD || s == D_HD) ? 4'(T_HD - 1) :
           (s == GAP)               ? 4'(T_GAP - 1) : 4'd0;
  endfunction
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      dir_q   <= 8'd0;
      dato_q  <= 8'd0;
      wr_op   <= 1'b0;
      datomem <= 8'd0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? dur(nxt) : (tc ? cnt : cnt - 4'd1);
      if (state == IDLE && req) begin
        dir_q  <= dir;
        dato_q <= dato;
        wr_op  <= actesc;
      end
      if (state == D_PW && tc && !wr_op) datomem <= ad_in;
    end
  end
  always_comb begin
    tc  = cnt == 4'd0;
    req = actesc | actlec;
    nxt = state == IDLE ? (req ? A_SU : IDLE) :
          state == DONE ? (req ? DONE : IDLE) :
          tc ? state_t'(state + 4'd1) : state;
    addr_ph      = state inside {A_SU, A_PW, A_HD};
    data_ph      = state inside {D_SU, D_PW, D_HD};
    cs_n         = !(addr_ph || data_ph);
    a_d          = data_ph;
    ad_oe        = addr_ph || (data_ph && wr_op);
    ad_out       = addr_ph ? dir_q : (data_ph && wr_op) ? dato_q : 8'd0;
    // The address is always latched with WR, even for read cycles.
    wr_n         = !(state == A_PW || (state == D_PW && wr_op));
    rd_n         = !(state == D_PW && !wr_op);
    esclisto     = state == DONE && wr_op;
    memorialisto = state == DONE && !wr_op;
  end
endmodule

// File: tb/tb_ciclo_bus_rtc.sv
// tb_ciclo_bus_rtc: randomized and directed checks of two ciclo_bus_rtc timings against a cycle-position model.
module tb_ciclo_bus_rtc;
  logic clk = 1'b0, reset = 1'b0, actesc = 1'b0, actlec = 1'b0;
  logic [7:0] dir = 8'd0, dato = 8'd0, ad_in = 8'd0;
  logic cs_n[2], rd_n[2], wr_n[2], a_d[2], ad_oe[2], esclisto[2], memorialisto[2];
  logic [7:0] ad_out[2], datomem[2];
  int su[2] = '{1, 2};
  int pw[2] = '{3, 5};
  int hd[2] = '{1, 2};
  int gp[2] = '{3 - 1, 3};
  int m_pos[2];
  bit m_busy[2], m_done[2], m_wr[2], en = 1'b0;
  logic [7:0] m_dir[2], m_dato[2], m_dm[2];
  int passed = 0, total = 0;
  int fd[2], dcnt[2], wa[2], wd[2], rl[2], mseen[2];

  always #5 clk = ~clk;

  ciclo_bus_rtc u0 (.clk(clk), .reset(reset), .actesc(actesc), .actlec(actlec), .dir(dir), .dato(dato),
    .ad_in(ad_in), .cs_n(cs_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]), .a_d(a_d[0]), .ad_out(ad_out[0]),
    .ad_oe(ad_oe[0]), .esclisto(esclisto[0]), .memorialisto(memorialisto[0]), .datomem(datomem[0]));
  ciclo_bus_rtc #(.T_SU(2), .T_PW(5), .T_HD(2), .T_GAP(3)) u1 (.clk(clk), .reset(reset), .actesc(actesc),
    .actlec(actlec), .dir(dir), .dato(dato), .ad_in(ad_in), .cs_n(cs_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
    .a_d(a_d[1]), .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .esclisto(esclisto[1]),
    .memorialisto(memorialisto[1]), .datomem(datomem[1]));

  // Model: a busy cycle is just a position 0..L-1 counted from the request edge.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      int p;
      p = su[i] + pw[i] + hd[i];
      if (!reset) begin
        m_busy[i] = 0; m_done[i] = 0; m_dm[i] = 8'd0;
      end else if (m_done[i]) begin
        if (!actesc && !actlec) m_done[i] = 0;
      end else if (m_busy[i]) begin
        if (!m_wr[i] && m_pos[i] == p + gp[i] + su[i] + pw[i] - 1) m_dm[i] = ad_in;
        m_pos[i]++;
        if (m_pos[i] == 2 * p + gp[i]) begin m_busy[i] = 0; m_done[i] = 1; end
      end else if (actesc || actlec) begin
        m_busy[i] = 1; m_pos[i] = 0; m_wr[i] = actesc; m_dir[i] = dir; m_dato[i] = dato;
      end
    end

  function automatic logic [22:0] expect_out(int i);
    logic cs, rd, wr, ad, oe;
    logic [7:0] ao;
    int p, o;
    bit data, strobe;
    cs = 1; rd = 1; wr = 1; ad = 0; oe = 0; ao = 8'd0;
    p = su[i] + pw[i] + hd[i];
    if (m_busy[i]) begin
      data = m_pos[i] >= p + gp[i];
      o = data ? m_pos[i] - p - gp[i] : m_pos[i];
      if (o < p) begin
        strobe = o >= su[i] && o < su[i] + pw[i];
        cs = 0; ad = data; oe = !data || m_wr[i];
        ao = !data ? m_dir[i] : m_wr[i] ? m_dato[i] : 8'd0;
        wr = !(strobe && (!data || m_wr[i]));
        rd = !(strobe && data && !m_wr[i]);
      end
    end
    return {cs, rd, wr, ad, oe, ao, m_done[i] && m_wr[i], m_done[i] && !m_wr[i], m_dm[i]};
  endfunction

  function automatic logic [22:0] got(int i);
    return {cs_n[i], rd_n[i], wr_n[i], a_d[i], ad_oe[i], ad_out[i], esclisto[i], memorialisto[i], datomem[i]};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  task automatic step();
    @(negedge clk);
    if (en) for (int i = 0; i < 2; i++) chk($sformatf("pins%0d", i), 32'(got(i)), 32'(expect_out(i)));
  endtask

  // Holds a request for `hold` cycles and records strobe/flag timing for both instances.
  task automatic run(input bit e, input bit l, input int hold, input logic [7:0] d, input logic [7:0] w);
    for (int i = 0; i < 2; i++) begin fd[i] = -1; dcnt[i] = 0; wa[i] = 0; wd[i] = 0; rl[i] = 0; mseen[i] = 0; end
    actesc = e; actlec = l; dir = d; dato = w;
    for (int n = 0; n < 40; n++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if ((esclisto[i] || memorialisto[i]) && fd[i] < 0) fd[i] = n;
        dcnt[i] += int'(esclisto[i] || memorialisto[i]);
        mseen[i] += int'(memorialisto[i]);
        wa[i] += int'(!wr_n[i] && !a_d[i] && ad_out[i] == d && !cs_n[i]);
        wd[i] += int'(!wr_n[i] && a_d[i] && ad_out[i] == w && !cs_n[i]);
        rl[i] += int'(!rd_n[i] && !ad_oe[i] && !cs_n[i]);
      end
      if (n == hold - 1) begin actesc = 0; actlec = 0; dir = ~d; dato = ~w; end
    end
  endtask

  initial begin
    step(); step();
    en = 1;
    step();
    chk("rst_cs", 32'(cs_n[0]), 1);
    chk("rst_datomem", 32'(datomem[0]), 0);
    chk("rst_oe", 32'(ad_oe[1]), 0);
    reset = 1;
    step();
    run(1, 0, 30, 8'h21, 8'h45);
    chk("wr_done_idx0", fd[0], 12);
    chk("wr_done_idx1", fd[1], 21);
    chk("wr_addr_strobe0", wa[0], 3);
    chk("wr_data_strobe0", wd[0], 3);
    chk("wr_addr_strobe1", wa[1], 5);
    chk("wr_data_strobe1", wd[1], 5);
    chk("wr_flag_held0", dcnt[0], 18);
    ad_in = 8'h37;
    run(0, 1, 30, 8'h41, 8'h00);
    chk("rd_strobe0", rl[0], 3);
    chk("rd_strobe1", rl[1], 5);
    chk("rd_done_idx0", fd[0], 12);
    chk("rd_datomem0", 32'(datomem[0]), 32'h37);
    chk("rd_datomem1", 32'(datomem[1]), 32'h37);
    chk("rd_addr_wr0", wa[0], 3);
    run(1, 1, 30, 8'h5a, 8'ha5);
    chk("both_done_idx0", fd[0], 12);
    chk("both_no_mem0", mseen[0], 0);
    chk("both_no_mem1", mseen[1], 0);
    run(1, 0, 1, 8'h11, 8'h22);
    chk("pulse_idx0", fd[0], 12);
    chk("pulse_len0", dcnt[0], 1);
    chk("pulse_len1", dcnt[1], 1);
    chk("pulse_wd0", wd[0], 3);
    actesc = 1; dir = 8'h33; dato = 8'h44;
    for (int n = 0; n < 10; n++) step();
    chk("mid_dpw_wr0", 32'(wr_n[0]), 0);
    reset = 0;
    step();
    chk("rst_mid_cs0", 32'(cs_n[0]), 1);
    chk("rst_mid_wr0", 32'(wr_n[0]), 1);
    chk("rst_mid_out0", 32'(ad_out[0]), 0);
    reset = 1; actesc = 0;
    step();
    run(1, 0, 30, 8'h66, 8'h77);
    chk("post_rst_idx0", fd[0], 12);
    chk("post_rst_wd0", wd[0], 3);
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(7) == 0) actesc = ~actesc;
      if ($urandom_range(7) == 0) actlec = ~actlec;
      dir = 8'($urandom); dato = 8'($urandom); ad_in = 8'($urandom);
      reset = $urandom_range(199) != 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ciclo_bus_rtc.md
# ciclo_bus_rtc

Bus-cycle generator for the external RTC's multiplexed address/data port. It sits directly downstream of `control_principal_rtc`. It consumes that controller's `actesc`/`actlec` requests together with the latched register address and write data. For each request it runs one complete Intel-style multiplexed cycle on the RTC pins: an address phase followed by a data phase. It then returns `esclisto`/`memorialisto` and the read byte `datomem` to the controller. Pin tristating is done at top level from `ad_oe`.

## Interface
Parameters:
- `T_SU`, default 1: setup clocks per phase (CS/A-D/bus valid before strobe). Range 1..15.
- `T_PW`, default 3: strobe-low clocks per phase. Range 1..15.
- `T_HD`, default 1: hold clocks per phase after strobe release. Range 1..15.
- `T_GAP`, default 2: CS-high clocks between address and data phase. Range 1..15.

Ports:
- `clk`, input, 1: system clock. The block uses one clock only.
- `reset`, input, 1: synchronous, active-low reset (asserted when `reset`==0, sampled on `clk` rising edge).
- `actesc`, input, 1: write request level from controller.
- `actlec`, input, 1: read request level from controller.
- `dir`, input, 8: RTC register address.
- `dato`, input, 8: write data.
- `ad_in`, input, 8: value read back from the AD pins.
- `cs_n`, output, 1: RTC chip select, active low.
- `rd_n`, output, 1: read strobe, active low.
- `wr_n`, output, 1: write strobe, active low.
- `a_d`, output, 1: phase select; 0 = address phase, 1 = data phase.
- `ad_out`, output, 8: value to drive on the AD pins.
- `ad_oe`, output, 1: AD pin output enable.
- `esclisto`, output, 1: write-cycle done.
- `memorialisto`, output, 1: read-cycle done.
- `datomem`, output, 8: last byte read.

## Operation
- Outputs are registered and decoded from the state register only. There is no combinational input-to-output path.
- Idle and reset values of the outputs:
  - `cs_n`=1, `rd_n`=1, `wr_n`=1, `a_d`=0
  - `ad_out`=0, `ad_oe`=0
  - `esclisto`=0, `memorialisto`=0
  - `datomem`=0 (reset only; otherwise `datomem` holds its last value)
- States: IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE. A 4-bit counter times each state.
- IDLE:
  - If `actesc`=1 or `actlec`=1, latch `dir`, `dato` and the op type, then go to A_SU.
  - `actesc` has priority when both are high (the op is a write).
- A_SU / A_PW / A_HD:
  - `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=latched `dir`.
  - `wr_n`=0 only in A_PW, for both reads and writes (the address is always latched with WR).
- GAP: `cs_n`=1, `ad_oe`=0, strobes high.
- D_SU / D_PW / D_HD: `cs_n`=0, `a_d`=1.
  - Write: `ad_oe`=1, `ad_out`=latched `dato`, `wr_n`=0 in D_PW.
  - Read: `ad_oe`=0, `rd_n`=0 in D_PW. `datomem` <= `ad_in` on the last D_PW cycle.
- DONE:
  - Bus released (idle pin values).
  - `esclisto`=1 for a write, or `memorialisto`=1 for a read.
  - The flag is held at least 1 cycle and until both `actesc` and `actlec` are 0, then the block returns to IDLE.
- Request dropped mid-cycle: the cycle is not aborted. It completes and passes through DONE for exactly 1 cycle.
- `dir`/`dato` changes after the request edge have no effect on the cycle in progress.
- Reset (`reset`=0) in any state: the next edge goes to IDLE with all outputs at their reset values. The bus is released immediately and the counter is cleared.

## Timing
- Each phase state lasts exactly its parameter count in clocks. The counter loads at state entry and the state exits when the counter hits its terminal count.
- If the request is sampled at edge k, `cs_n` falls at edge k.
- DONE (flag high) is entered at edge k+L, where L = 2·(T_SU+T_PW+T_HD)+T_GAP. With the defaults, L = 12.
- Minimum spacing between back-to-back cycles: the request must be seen low in DONE, then 1 IDLE cycle, so the next cycle starts at edge ≥ k+L+2.
- `ad_oe` and `ad_out` are stable for the whole CS-low window of a phase. Strobe edges never coincide with a CS, A/D or data change, because T_SU and T_HD are ≥1.

## Test plan
- Write, defaults: `dir`=0x21, `dato`=0x45, `actesc` held high.
  - `wr_n` low 3 cycles with `a_d`=0, `ad_out`=0x21.
  - 2 CS-high gap cycles.
  - `wr_n` low 3 cycles with `a_d`=1, `ad_out`=0x45.
  - `esclisto`=1 at k+12, held until `actesc` drops, then IDLE.
- Read: `dir`=0x41, `actlec`=1, `ad_in`=0x37 during D_PW.
  - `rd_n` low 3 cycles with `ad_oe`=0.
  - `datomem`=0x37 and `memorialisto`=1 at k+12.
- Simultaneous `actesc`=`actlec`=1: a write cycle runs, `esclisto` asserts and `memorialisto` stays 0.
- Request pulse of 1 cycle: the full 12-cycle cycle still completes, and the flag is high for exactly 1 cycle.
- `reset`=0 during D_PW of a write: on the next edge all outputs are at reset values and the state is IDLE. A subsequent request then runs a clean cycle.
- T_SU=2, T_PW=5, T_HD=2, T_GAP=3: DONE is entered at k+21, and each strobe is exactly 5 cycles.
